// File: rtl/fir_mac_scheduler.sv
// ----------------------------------------------------------------------------
// fir_mac_scheduler
//
// Purpose: shares one serial N_TAPS-tap MAC FIR engine among N_CH channels.
// Per-channel sample strobes are latched into hold registers and arbitrated
// round-robin. Each granted sample is written into its channel's circular
// delay line, followed by an N_TAPS-cycle MAC sweep and a dump. The engine
// result is returned tagged with its channel.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ch_valid/data   per-channel one-cycle sample strobe and packed samples
//   flush           one-cycle request to zero every delay line
//   ch_overrun      one-cycle pulse: an unserved sample was overwritten
//   busy            high whenever the scheduler is not idle
//   eng_wr_*        delay RAM write port {channel, slot}
//   eng_rd_*        delay RAM read / MAC step {channel, slot}, coef index
//   eng_acc_clr     MAC step loads the product instead of accumulating
//   eng_dump        one-cycle request for the engine result
//   eng_res(_valid) engine result, valid in the dump cycle or later
//   out_*           one-cycle result strobe with channel tag and data
// ----------------------------------------------------------------------------
module fir_mac_scheduler #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned N_TAPS = 64,
    parameter int unsigned TAP_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_valid,
    input  logic [N_CH*WIDTH-1:0]   ch_data,
    input  logic                    flush,
    output logic [N_CH-1:0]         ch_overrun,
    output logic                    busy,
    output logic                    eng_wr_en,
    output logic [CH_W+TAP_W-1:0]   eng_wr_addr,
    output logic [WIDTH-1:0]        eng_wr_data,
    output logic                    eng_rd_en,
    output logic [CH_W+TAP_W-1:0]   eng_rd_addr,
    output logic [TAP_W-1:0]        eng_coef_idx,
    output logic                    eng_acc_clr,
    output logic                    eng_dump,
    input  logic [WIDTH-1:0]        eng_res,
    input  logic                    eng_res_valid,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic [WIDTH-1:0]        out_data
);

    localparam int unsigned AW = CH_W + TAP_W;
    localparam logic [AW-1:0]    LastCnt = AW'(N_CH * N_TAPS - 1);
    localparam logic [TAP_W-1:0] LastTap = TAP_W'(N_TAPS - 1);

    typedef enum logic [2:0] {
        StFlush,
        StIdle,
        StWrite,
        StMac,
        StDump,
        StWait
    } state_e;

    // Control state
    state_e              r_state;
    logic [AW-1:0]       r_cnt;
    logic [N_CH-1:0]     r_pending;
    logic [WIDTH-1:0]    r_hold [N_CH];
    logic [TAP_W-1:0]    r_wptr [N_CH];
    logic [CH_W-1:0]     r_last_grant;
    logic [CH_W-1:0]     r_cur_ch;
    logic [TAP_W-1:0]    r_base;
    logic                r_flush_req;

    // Registered outputs
    logic [N_CH-1:0]     r_overrun;
    logic                r_busy;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic                r_rd_en;
    logic [AW-1:0]       r_rd_addr;
    logic [TAP_W-1:0]    r_coef_idx;
    logic                r_acc_clr;
    logic                r_dump;
    logic                r_out_valid;
    logic [CH_W-1:0]     r_out_ch;
    logic [WIDTH-1:0]    r_out_data;

    // Next-state / combinational
    state_e              w_state_d;
    logic [AW-1:0]       w_cnt_d;
    logic [TAP_W-1:0]    w_base_d;
    logic [TAP_W-1:0]    w_k_n;
    logic [CH_W-1:0]     w_scan;
    logic [CH_W-1:0]     w_pick;
    logic                w_any;
    logic                w_grant;
    logic [N_CH-1:0]     w_grant_vec;
    logic                w_flush_issue;
    logic                w_flush_done;
    logic                w_wptr_inc;
    logic                w_capture;
    logic                w_busy_d;
    logic                w_wr_en_d;
    logic [AW-1:0]       w_wr_addr_d;
    logic [WIDTH-1:0]    w_wr_data_d;
    logic                w_rd_en_d;
    logic [AW-1:0]       w_rd_addr_d;
    logic [TAP_W-1:0]    w_coef_d;
    logic                w_acc_clr_d;
    logic                w_dump_d;

    // Round-robin pick: scan offsets from N_CH down to 1 so the nearest
    // pending channel after last_grant is the final (winning) assignment.
    always_comb begin
        w_scan = r_last_grant;
        w_pick = r_last_grant;
        w_any  = 1'b0;
        for (int i = N_CH; i >= 1; i--) begin
            w_scan = r_last_grant + CH_W'(i);
            if (r_pending[w_scan]) begin
                w_any  = 1'b1;
                w_pick = w_scan;
            end
        end
    end

    always_comb begin
        w_grant_vec = '0;
        if (w_grant) begin
            w_grant_vec[w_pick] = 1'b1;
        end
    end

    assign w_k_n = r_cnt[TAP_W-1:0] + 1'b1;

    // All engine outputs are computed for the next cycle and registered, so
    // they line up with the state the FSM is entering. Flush writes are the
    // exception: the slot in r_cnt is issued into the following cycle, which
    // lets the reset-state FLUSH start cleanly at slot 0.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_base_d      = r_base;
        w_grant       = 1'b0;
        w_flush_issue = 1'b0;
        w_flush_done  = 1'b0;
        w_wptr_inc    = 1'b0;
        w_capture     = 1'b0;
        w_wr_en_d     = 1'b0;
        w_wr_addr_d   = '0;
        w_wr_data_d   = '0;
        w_rd_en_d     = 1'b0;
        w_rd_addr_d   = '0;
        w_coef_d      = '0;
        w_acc_clr_d   = 1'b0;
        w_dump_d      = 1'b0;

        unique case (r_state)
            StFlush: begin
                w_flush_issue = 1'b1;
                w_wr_en_d     = 1'b1;
                w_wr_addr_d   = r_cnt;
                w_cnt_d       = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    w_flush_done = 1'b1;
                    w_cnt_d      = '0;
                    w_state_d    = StIdle;
                end
            end
            StIdle: begin
                if (r_flush_req) begin
                    // Issue slot 0 now; FLUSH continues from slot 1.
                    w_flush_issue = 1'b1;
                    w_wr_en_d     = 1'b1;
                    w_wr_addr_d   = '0;
                    w_cnt_d       = AW'(1);
                    w_state_d     = StFlush;
                end else if (w_any) begin
                    w_grant     = 1'b1;
                    w_wr_en_d   = 1'b1;
                    w_wr_addr_d = {w_pick, r_wptr[w_pick]};
                    w_wr_data_d = r_hold[w_pick];
                    w_state_d   = StWrite;
                end
            end
            StWrite: begin
                w_base_d    = r_wptr[r_cur_ch];
                w_wptr_inc  = 1'b1;
                w_cnt_d     = '0;
                w_rd_en_d   = 1'b1;
                w_rd_addr_d = {r_cur_ch, r_wptr[r_cur_ch]};
                w_coef_d    = '0;
                w_acc_clr_d = 1'b1;
                w_state_d   = StMac;
            end
            StMac: begin
                if (r_cnt[TAP_W-1:0] == LastTap) begin
                    w_cnt_d   = '0;
                    w_dump_d  = 1'b1;
                    w_state_d = StDump;
                end else begin
                    w_cnt_d     = AW'(w_k_n);
                    w_rd_en_d   = 1'b1;
                    w_coef_d    = w_k_n;
                    // Newest sample pairs with coefficient 0, walking back.
                    w_rd_addr_d = {r_cur_ch, r_base - w_k_n};
                end
            end
            StDump: begin
                if (eng_res_valid) begin
                    w_capture = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (eng_res_valid) begin
                    w_capture = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_busy_d = (w_state_d != StIdle) || w_flush_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StFlush;
            r_cnt        <= '0;
            r_base       <= '0;
            r_pending    <= '0;
            r_last_grant <= CH_W'(N_CH - 1);
            r_cur_ch     <= '0;
            r_flush_req  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
                r_wptr[i] <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_base      <= w_base_d;
            // A strobe on a channel granted this cycle re-arms its pending bit.
            r_pending   <= (r_pending & ~w_grant_vec) | ch_valid;
            r_flush_req <= (r_flush_req & ~w_flush_done) | flush;
            for (int i = 0; i < N_CH; i++) begin
                if (ch_valid[i]) begin
                    r_hold[i] <= ch_data[i*WIDTH +: WIDTH];
                end
            end
            if (w_grant) begin
                r_cur_ch     <= w_pick;
                r_last_grant <= w_pick;
            end
            if (w_flush_done) begin
                for (int i = 0; i < N_CH; i++) begin
                    r_wptr[i] <= '0;
                end
            end else if (w_wptr_inc) begin
                r_wptr[r_cur_ch] <= r_wptr[r_cur_ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= '0;
            r_busy      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_coef_idx  <= '0;
            r_acc_clr   <= 1'b0;
            r_dump      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_overrun   <= ch_valid & r_pending & ~w_grant_vec;
            r_busy      <= w_busy_d;
            r_wr_en     <= w_wr_en_d;
            r_wr_addr   <= w_wr_addr_d;
            r_wr_data   <= w_wr_data_d;
            r_rd_en     <= w_rd_en_d;
            r_rd_addr   <= w_rd_addr_d;
            r_coef_idx  <= w_coef_d;
            r_acc_clr   <= w_acc_clr_d;
            r_dump      <= w_dump_d;
            r_out_valid <= w_capture;
            if (w_capture) begin
                r_out_ch   <= r_cur_ch;
                r_out_data <= eng_res;
            end
        end
    end

    assign ch_overrun   = r_overrun;
    assign busy         = r_busy;
    assign eng_wr_en    = r_wr_en;
    assign eng_wr_addr  = r_wr_addr;
    assign eng_wr_data  = r_wr_data;
    assign eng_rd_en    = r_rd_en;
    assign eng_rd_addr  = r_rd_addr;
    assign eng_coef_idx = r_coef_idx;
    assign eng_acc_clr  = r_acc_clr;
    assign eng_dump     = r_dump;
    assign out_valid    = r_out_valid;
    assign out_ch       = r_out_ch;
    assign out_data     = r_out_data;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fir_mac_scheduler
//
// Directed bench for fir_mac_scheduler (4 channels, 64 taps, 18-bit data).
// A trivial engine model answers eng_dump with a bench-chosen result, either
// in the dump cycle or after a programmed delay.
// ----------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_valid;
    logic [71:0] ch_data;
    logic        flush;
    logic [3:0]  ch_overrun;
    logic        busy;
    logic        eng_wr_en;
    logic [7:0]  eng_wr_addr;
    logic [17:0] eng_wr_data;
    logic        eng_rd_en;
    logic [7:0]  eng_rd_addr;
    logic [5:0]  eng_coef_idx;
    logic        eng_acc_clr;
    logic        eng_dump;
    logic [17:0] eng_res;
    logic        eng_res_valid;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [17:0] out_data;

    logic [17:0] res_val;
    logic        zero_lat;
    logic        late_v;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_w   = 0;
    int w0;

    assign eng_res       = res_val;
    assign eng_res_valid = (eng_dump & zero_lat) | late_v;

    fir_mac_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .flush        (flush),
        .ch_overrun   (ch_overrun),
        .busy         (busy),
        .eng_wr_en    (eng_wr_en),
        .eng_wr_addr  (eng_wr_addr),
        .eng_wr_data  (eng_wr_data),
        .eng_rd_en    (eng_rd_en),
        .eng_rd_addr  (eng_rd_addr),
        .eng_coef_idx (eng_coef_idx),
        .eng_acc_clr  (eng_acc_clr),
        .eng_dump     (eng_dump),
        .eng_res      (eng_res),
        .eng_res_valid(eng_res_valid),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [17:0] d0, input logic [17:0] d1,
                          input logic [17:0] d2, input logic [17:0] d3);
        ch_valid = mask;
        ch_data  = {d3, d2, d1, d0};
        step();
        ch_valid = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, eng_wr_en, eng_rd_en, eng_coef_idx, eng_acc_clr, eng_dump,
                              out_valid, ch_overrun, eng_rd_addr}, 32'd0);
        check({tag, "_wr"}, {eng_wr_addr, eng_wr_data}, 32'd0);
        check({tag, "_out"}, {out_ch, out_data}, 32'd0);
    endtask

    // 256 zero writes over the whole delay RAM, then idle.
    task automatic flush_check();
        for (int c = 0; c < 256; c++) begin
            step();
            check("flush_wr", {busy, eng_wr_en, eng_rd_en, eng_wr_addr, eng_wr_data},
                  {1'b1, 1'b1, 1'b0, 8'(c), 18'd0});
        end
        step();
        check("flush_end_idle", {busy, eng_wr_en, eng_rd_en, eng_dump, out_valid}, 32'd0);
    endtask

    // One full service: WRITE, 64 MAC steps, DUMP, optional WAIT, result.
    // With inj set, channel 1 is strobed twice mid-sweep to provoke an overrun.
    task automatic run_service(input int ch, input int slot, input logic [17:0] data,
                               input logic [17:0] res, input int lat, input bit inj);
        int n;
        int t_w;
        logic [7:0]  ea;
        logic [16:0] em;
        logic [3:0]  eo;
        res_val  = res;
        zero_lat = (lat == 0);
        n = 0;
        while (eng_wr_en !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("grant_seen", eng_wr_en, 1'b1);
        t_w    = cyc;
        last_w = cyc;
        check("wr_addr", eng_wr_addr, {ch[1:0], slot[5:0]});
        check("wr_data", eng_wr_data, data);
        for (int k = 0; k < 64; k++) begin
            if (inj && k == 5) begin
                ch_valid = 4'b0010;
                ch_data[18 +: 18] = 18'd100;
            end
            if (inj && k == 6) ch_data[18 +: 18] = 18'd200;
            if (inj && k == 7) ch_valid = '0;
            step();
            ea = {ch[1:0], 6'(slot - k)};
            em = {1'b1, ea, 6'(k), (k == 0), 1'b0};
            check("mac_step", {eng_rd_en, eng_rd_addr, eng_coef_idx, eng_acc_clr, eng_wr_en}, em);
            eo = (inj && k == 6) ? 4'b0010 : 4'b0000;
            check("overrun", ch_overrun, eo);
        end
        step();
        check("dump", {eng_dump, eng_rd_en, busy}, 3'b101);
        if (lat > 0) begin
            for (int j = 0; j < lat; j++) begin
                step();
                check("wait", {eng_dump, out_valid, busy}, 3'b001);
            end
            late_v = 1'b1;
            step();
            late_v = 1'b0;
        end else begin
            step();
        end
        check("out_valid", out_valid, 1'b1);
        check("out_ch", out_ch, ch[1:0]);
        check("out_data", out_data, res);
        check("latency", cyc - t_w, 66 + lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        ch_valid = '0;
        ch_data  = '0;
        flush    = 1'b0;
        res_val  = '0;
        zero_lat = 1'b1;
        late_v   = 1'b0;

        // Reset, then the automatic full-RAM flush with no traffic.
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        flush_check();
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_quiet", {busy, eng_wr_en, eng_rd_en, eng_dump, out_valid}, 32'd0);
        end

        // Single sample on ch2; ch1 overruns (100 then 200) during the sweep.
        strobe(4'b0100, 18'd0, 18'd0, 18'd1000, 18'd0);
        run_service(2, 0, 18'd1000, 18'd5, 0, 1'b1);
        step();
        check("out_pulse_end", out_valid, 1'b0);
        check("out_hold", {out_ch, out_data}, {2'd2, 18'd5});

        // ch1 is served with the newer value; engine answers 3 cycles late.
        run_service(1, 0, 18'd200, 18'h3fff9, 3, 1'b0);

        // 65 samples on ch0 wrap its delay line; other banks untouched.
        for (int n = 0; n < 65; n++) begin
            strobe(4'b0001, 18'(n + 1), 18'd0, 18'd0, 18'd0);
            run_service(0, n % 64, 18'(n + 1), 18'(3 * n), 0, 1'b0);
        end
        strobe(4'b0100, 18'd0, 18'd0, 18'd300, 18'd0);
        run_service(2, 1, 18'd300, 18'd77, 0, 1'b0);

        // Explicit flush request from idle.
        flush = 1'b1;
        step();
        flush = 1'b0;
        flush_check();

        // Reset mid-MAC with ch3 left pending.
        strobe(4'b0010, 18'd0, 18'd50, 18'd0, 18'd0);
        for (int n = 0; n < 10 && eng_wr_en !== 1'b1; n++) step();
        check("post_flush_wptr", {eng_wr_en, eng_wr_addr}, {1'b1, 8'h40});
        for (int n = 0; n < 10; n++) step();
        strobe(4'b1000, 18'd0, 18'd0, 18'd0, 18'd77);
        check("pre_rst_mac", eng_rd_en, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        check_all_zero("rst_held");
        rst = 1'b0;
        flush_check();
        for (int i = 0; i < 5; i++) begin
            step();
            check("pending_cleared", {busy, eng_wr_en}, 2'b00);
        end

        // All four at once: served 0,1,2,3, 67 cycles apart.
        strobe(4'b1111, 18'd11, 18'd12, 18'd13, 18'd14);
        run_service(0, 0, 18'd11, 18'd100, 0, 1'b0);
        w0 = last_w;
        run_service(1, 0, 18'd12, 18'd101, 0, 1'b0);
        check("period_01", last_w - w0, 67);
        w0 = last_w;
        run_service(2, 0, 18'd13, 18'd102, 0, 1'b0);
        check("period_12", last_w - w0, 67);
        w0 = last_w;
        run_service(3, 0, 18'd14, 18'd103, 0, 1'b0);
        check("period_23", last_w - w0, 67);

        // ch3 and ch0 together after ch3 was last: ch0 first.
        strobe(4'b1001, 18'd21, 18'd0, 18'd0, 18'd24);
        run_service(0, 1, 18'd21, 18'd200, 0, 1'b0);
        run_service(3, 1, 18'd24, 18'd201, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Round-robin scheduler that shares one serial 64-tap MAC FIR engine among N_CH sample channels.
- Latches per-channel sample strobes and arbitrates between pending channels.
- Sequences the engine: delay-line write, tap-indexed MAC sweep, accumulator clear and dump.
- Returns each filtered result tagged with its channel. It sits between the channel front-ends and the shared coefficient ROM / banked delay RAM / MAC datapath.

Parameters:
WIDTH, 18, sample/result width (signed)
N_CH, 4, number of channels (power of 2)
CH_W, 2, log2(N_CH)
N_TAPS, 64, taps per filter (power of 2)
TAP_W, 6, log2(N_TAPS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
ch_valid  in  N_CH  per-channel one-cycle sample strobe
ch_data  in  N_CH*WIDTH  channel i sample at bits [i*WIDTH +: WIDTH], signed
flush  in  1  one-cycle request to zero all delay lines
ch_overrun  out  N_CH  one-cycle pulse: unserved sample overwritten
busy  out  1  high in any state except IDLE
eng_wr_en  out  1  delay RAM write enable
eng_wr_addr  out  CH_W+TAP_W  {channel, slot}
eng_wr_data  out  WIDTH  data to write
eng_rd_en  out  1  delay RAM read / MAC step valid
eng_rd_addr  out  CH_W+TAP_W  {channel, slot}
eng_coef_idx  out  TAP_W  coefficient index for this MAC step
eng_acc_clr  out  1  MAC step loads the product instead of accumulating
eng_dump  out  1  one-cycle request for the engine to output its result
eng_res  in  WIDTH  engine result
eng_res_valid  in  1  eng_res valid; legal in the eng_dump cycle or later
out_valid  out  1  one-cycle result strobe
out_ch  out  CH_W  channel of the result
out_data  out  WIDTH  filtered sample

Behaviour:
- Reset (async): all outputs 0; pending, hold registers and wptr[] cleared; last_grant = N_CH-1; state = FLUSH, cnt = 0.
- Capture, every cycle, any state: ch_valid[i] loads hold[i] and sets pending[i].
  - If pending[i] is already set and channel i is not granted that cycle: ch_overrun[i] = 1 next cycle and the newer value replaces the old.
  - If channel i is granted in the same cycle: pending stays set with the new value, no overrun.
- flush pulse: sets flush_req (sticky), which is serviced from IDLE.
- FSM states: FLUSH, IDLE, WRITE, MAC, DUMP, WAIT.
- FLUSH: N_CH*N_TAPS cycles. eng_wr_en = 1, eng_wr_addr = cnt, eng_wr_data = 0, cnt increments. On the last count: clear flush_req and wptr[], go to IDLE.
- IDLE:
  - flush_req has priority and goes to FLUSH.
  - Otherwise, if any pending: grant the first pending channel searching from last_grant+1 with wrap. Copy hold[ch] to cur_data, clear pending[ch], set last_grant = ch, go to WRITE.
- WRITE (1 cycle): eng_wr_en = 1, eng_wr_addr = {ch, wptr[ch]}, eng_wr_data = cur_data. Latch base = wptr[ch]; wptr[ch] increments (mod N_TAPS). Go to MAC with k = 0.
- MAC (N_TAPS cycles, k = 0..N_TAPS-1): eng_rd_en = 1, eng_coef_idx = k, eng_rd_addr = {ch, base - k} (mod N_TAPS), eng_acc_clr = (k == 0). After k = N_TAPS-1, go to DUMP.
- DUMP (1 cycle): eng_dump = 1.
  - If eng_res_valid is high in this cycle: capture the result and go to IDLE.
  - Otherwise go to WAIT.
- WAIT: hold until eng_res_valid, capture, go to IDLE. There is no timeout.
- Result output: out_valid pulses exactly 1 cycle after the eng_res_valid capture, with out_ch = ch and out_data = eng_res. out_ch and out_data hold until the next result.
- Timing: with zero engine latency, grant to out_valid = N_TAPS+3 = 67 cycles; channel service period = 67 cycles.
- A flush request never interrupts an in-flight sample; it waits for IDLE. Samples arriving during FLUSH are kept pending.
- All engine strobes are registered outputs and are 0 outside their states.

Test Plan:
1. Reset release, no traffic -> busy = 1 for 256 cycles; eng_wr_addr runs 0..255 with eng_wr_data = 0; then IDLE, busy = 0, no other strobes.
2. After flush, ch_valid = 4'b0100 with ch_data[2] = 18'sd1000:
   - WRITE to addr {2,0} with data 1000.
   - 64 MAC cycles with rd_addr {2,0},{2,63},{2,62}…{2,1}, coef_idx 0..63, acc_clr only at k = 0.
   - Engine returns 18'sd5 in the dump cycle -> out_valid, out_ch = 2, out_data = 5, 67 cycles after grant.
3. ch_valid = 4'b1111 in one cycle -> grants in order 0,1,2,3, each 67 cycles apart. A following ch_valid on channels 3 and 0 -> ch0 is served first.
4. ch1 strobes 100, then 200 before ch1 is granted -> ch_overrun[1] pulses once; ch1's WRITE data = 200.
5. 65 samples on ch0 -> the 64th write goes to {0,63}; the 65th write goes to {0,0}, with MAC reads {0,0},{0,63},…; no corruption of other banks.
6. rst asserted mid-MAC -> all outputs 0 asynchronously, pending cleared. After release, FLUSH restarts from addr 0 and the next grant is ch0.
